comp_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered N-bit magnitude comparator among NREQ requesters.
- Each requester posts an operand pair (A, B) and a mode bit. Mode 0 is an unsigned compare. Mode 1 is a two's-complement compare, done by inverting both MSBs and comparing unsigned.
- The block serialises requests, drives the shared comparator core, and returns Mayor/Igual/Menor with a one-cycle done pulse to the granted requester.
- Sits between several comb/seq clients and a single compare resource, saving (NREQ-1) comparator instances.

---
 rtl/comp_arb_pkg.sv | 30 +++
 rtl/comp_arb_core.sv | 67 ++++++
 rtl/comp_arb.sv | 155 +++++++++++++++
 tb/tb_comp_arb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_arb_pkg
// Description : Shared definitions for the comp_arb shared-comparator arbiter:
//               FSM state encodings, the MSB-flip mask helper and the
//               operation-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_COMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CNT_W = 16;
    localparam int MAX_W = 64;

    // Mask with only bit (width-1) set; XOR with it maps two's complement
    // ordering onto unsigned ordering.
    function automatic logic [MAX_W-1:0] msb_mask(input int width);
        logic [MAX_W-1:0] m;
        m = {{(MAX_W-1){1'b0}}, 1'b1} << (width - 1);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comp_arb_core.sv
`default_nettype none
// ============================================================================
// Module      : comp_arb_core
// Description : Shared magnitude comparator. Operands are captured (and
//               sign-converted when i_Mode=1) on i_Load; gt/eq flags are
//               registered on i_Comp.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_arb_core
    import comp_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Load,
    input  logic         i_Comp,
    input  logic [N-1:0] i_A,
    input  logic [N-1:0] i_B,
    input  logic         i_Mode,
    output logic         o_Gt,
    output logic         o_Eq
);

    localparam logic [N-1:0] C_MSB = N'(msb_mask(N));

    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         gt_q, gt_d;
    logic         eq_q, eq_d;

    // Operand capture with mode conversion, then flag evaluation one cycle later.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        gt_d = gt_q;
        eq_d = eq_q;
        if (i_Load) begin
            a_d = i_Mode ? (i_A ^ C_MSB) : i_A;
            b_d = i_Mode ? (i_B ^ C_MSB) : i_B;
        end
        if (i_Comp) begin
            gt_d = (a_q > b_q);
            eq_d = (a_q == b_q);
        end
    end

    // Operand and flag registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            a_q  <= '0;
            b_q  <= '0;
            gt_q <= 1'b0;
            eq_q <= 1'b0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            gt_q <= gt_d;
            eq_q <= eq_d;
        end
    end

    assign o_Gt = gt_q;
    assign o_Eq = eq_q;

endmodule
`default_nettype wire

// File: rtl/comp_arb.sv
`default_nettype none
// ============================================================================
// Module      : comp_arb
// Description : Round-robin arbiter/sequencer sharing one registered
//               comparator among NREQ requesters. Each op runs LOAD, COMP,
//               DONE. Optional macro COMP_ARB_CNT_EN adds a saturating
//               16-bit o_OpCount of completed operations.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_arb
    import comp_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NREQ-1:0]   i_Req,
    input  logic [NREQ*N-1:0] i_A,
    input  logic [NREQ*N-1:0] i_B,
    input  logic [NREQ-1:0]   i_Ctrl,
    output logic [NREQ-1:0]   o_Gnt,
    output logic [NREQ-1:0]   o_Done,
    output logic              o_Mayor,
    output logic              o_Igual,
    output logic              o_Menor,
    output logic              o_Busy
`ifdef COMP_ARB_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_OpCount
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] w_win_oh;
    logic [NREQ-1:0] w_req_eff;
    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [IW-1:0]   w_pick_next;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;
    logic            w_sel_mode;
    logic            w_gt;
    logic            w_eq;
    logic            w_in_done;

    assign w_win_oh  = NREQ'(1) << win_q;
    assign w_in_done = (state_q == ST_DONE);

    // Round-robin search from the pointer; the current grantee is masked in DONE.
    always_comb begin
        int idx;
        idx         = 0;
        w_req_eff   = (state_q == ST_DONE) ? (i_Req & ~w_win_oh) : i_Req;
        w_found     = 1'b0;
        w_pick      = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr_q) + i) % NREQ;
            if (!w_found && w_req_eff[idx]) begin
                w_found = 1'b1;
                w_pick  = IW'(idx);
            end
        end
        w_pick_next = IW'((int'(w_pick) + 1) % NREQ);
    end

    // Next-state logic; winner and pointer change only on entry to LOAD.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_found) begin
                    state_d = ST_LOAD;
                    win_d   = w_pick;
                    ptr_d   = w_pick_next;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_COMP;
            ST_COMP: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, winner and round-robin pointer registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
        end
    end

    assign w_sel_a    = i_A[int'(win_q)*N +: N];
    assign w_sel_b    = i_B[int'(win_q)*N +: N];
    assign w_sel_mode = i_Ctrl[win_q];

    comp_arb_core #(
        .N (N)
    ) u_core (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Load (state_q == ST_LOAD),
        .i_Comp (state_q == ST_COMP),
        .i_A    (w_sel_a),
        .i_B    (w_sel_b),
        .i_Mode (w_sel_mode),
        .o_Gt   (w_gt),
        .o_Eq   (w_eq)
    );

    assign o_Busy  = (state_q != ST_IDLE);
    assign o_Gnt   = o_Busy    ? w_win_oh : '0;
    assign o_Done  = w_in_done ? w_win_oh : '0;
    assign o_Mayor = w_in_done & w_gt;
    assign o_Igual = w_in_done & w_eq;
    assign o_Menor = w_in_done & ~w_gt & ~w_eq;

`ifdef COMP_ARB_CNT_EN
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

    // Saturating count of completed operations.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (w_in_done && (op_cnt_q != {CNT_W{1'b1}})) begin
            op_cnt_d = op_cnt_q + 1'b1;
        end
    end

    // Operation counter register.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            op_cnt_q <= '0;
        end else begin
            op_cnt_q <= op_cnt_d;
        end
    end

    assign o_OpCount = op_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_comp_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_arb
// Description : Self-checking bench for comp_arb (N=8, NREQ=4). Optional
//               counter checks are built when COMP_ARB_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_arb;

    localparam int N    = 8;
    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a;
    logic [NREQ*N-1:0] b;
    logic [NREQ-1:0]   ctrl;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              mayor;
    logic              igual;
    logic              menor;
    logic              busy;
`ifdef COMP_ARB_CNT_EN
    logic [15:0]       opcount;
`endif

    comp_arb #(.N(N), .NREQ(NREQ)) dut (
        .i_Clk   (clk),
        .i_Rst   (rst),
        .i_Req   (req),
        .i_A     (a),
        .i_B     (b),
        .i_Ctrl  (ctrl),
        .o_Gnt   (gnt),
        .o_Done  (done),
        .o_Mayor (mayor),
        .o_Igual (igual),
        .o_Menor (menor),
        .o_Busy  (busy)
`ifdef COMP_ARB_CNT_EN
        ,
        .o_OpCount (opcount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic m;
        logic e;
        logic l;
    } exp_t;

    typedef struct {
        int         k;
        logic [7:0] va;
        logic [7:0] vb;
        logic       md;
        logic       m;
        logic       e;
        logic       l;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Independent reference: native signed/unsigned comparison.
    function automatic exp_t model(input int k, input logic [7:0] va, input logic [7:0] vb, input logic md);
        exp_t r;
        r.idx = k;
        if (md) begin
            r.m = ($signed(va) > $signed(vb));
            r.l = ($signed(va) < $signed(vb));
        end else begin
            r.m = (va > vb);
            r.l = (va < vb);
        end
        r.e = (va == vb);
        return r;
    endfunction

    // Scoreboard monitor: every o_Done pops one expected record.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("done_onehot0", 32'($onehot0(done)), 32'd1);
            if (|done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_idx", 32'(done), 32'(4'b0001 << e.idx));
                    check("done_gnt", 32'(gnt), 32'(done));
                    check("flags", {29'd0, mayor, igual, menor}, {29'd0, e.m, e.e, e.l});
                end
            end else begin
                check("flags_idle", {29'd0, mayor, igual, menor}, 32'd0);
            end
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", {18'd0, gnt, done, mayor, igual, menor, busy}, 32'd0);
        rst = 1'b0;
    endtask

    task automatic set_op(input int k, input logic [7:0] va, input logic [7:0] vb, input logic md);
        a[k*N +: N] = va;
        b[k*N +: N] = vb;
        ctrl[k]     = md;
    endtask

    task automatic wait_idle;
        for (int c = 0; c < 20; c++) begin
            if (!busy) return;
            @(negedge clk);
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input int k);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done[k]) return;
        end
        check("done_timeout", 32'(done[k]), 32'd1);
    endtask

    task automatic run_op(input int k, input logic [7:0] va, input logic [7:0] vb, input logic md, input exp_t ex);
        wait_idle();
        set_op(k, va, vb, md);
        sb.push_back(ex);
        req[k] = 1'b1;
        wait_done(k);
        req[k] = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int   t_prev;
        int   n;
        exp_t ex;
        logic [7:0] ra, rb;
        logic rm;

        vecs[0] = '{0, 8'h05, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{2, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{3, 8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1, 8'h03, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1};

        req = '0; a = '0; b = '0; ctrl = '0; rst = 1'b1;
        do_reset();

        // Single op with latency: gnt one cycle after sampling, done two later.
        @(negedge clk);
        set_op(0, 8'h05, 8'h03, 1'b0);
        sb.push_back('{0, 1'b1, 1'b0, 1'b0});
        req = 4'b0001;
        @(negedge clk);
        check("lat_gnt1", {24'd0, gnt, done}, {24'd0, 4'b0001, 4'b0000});
        @(negedge clk);
        check("lat_gnt2", {24'd0, gnt, done}, {24'd0, 4'b0001, 4'b0000});
        @(negedge clk);
        check("lat_done", 32'(done), 32'(4'b0001));
        req = '0;

        // Table of directed vectors.
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].k, vecs[i].va, vecs[i].vb, vecs[i].md,
                   '{vecs[i].k, vecs[i].m, vecs[i].e, vecs[i].l});
        end

        // Random ops checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i == 3) ? ra : 8'($urandom_range(0, 255));
            rm = 1'($urandom_range(0, 1));
            run_op(i % NREQ, ra, rb, rm, model(i % NREQ, ra, rb, rm));
        end

        // All four requesting: order 0,1,2,3,0 at 3-cycle spacing.
        wait_idle();
        do_reset();
        for (int k = 0; k < NREQ; k++) set_op(k, 8'(k + 1), 8'h02, 1'b0);
        sb.push_back(model(0, 8'h01, 8'h02, 1'b0));
        sb.push_back(model(1, 8'h02, 8'h02, 1'b0));
        sb.push_back(model(2, 8'h03, 8'h02, 1'b0));
        sb.push_back(model(3, 8'h04, 8'h02, 1'b0));
        sb.push_back(model(0, 8'h01, 8'h02, 1'b0));
        req = 4'hF;
        n = 0; t_prev = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (|done) begin
                if (n > 0) check("rr_spacing", 32'(cyc - t_prev), 32'd3);
                t_prev = cyc;
                n++;
                if (n == 5) req = '0;
            end
        end
        check("rr_count", 32'(n), 32'd5);

        // Sole requester held high: 4-cycle period through IDLE.
        wait_idle();
        set_op(2, 8'h10, 8'h20, 1'b0);
        for (int i = 0; i < 3; i++) sb.push_back(model(2, 8'h10, 8'h20, 1'b0));
        req = 4'b0100;
        n = 0; t_prev = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (|done) begin
                if (n > 0) check("sole_period", 32'(cyc - t_prev), 32'd4);
                t_prev = cyc;
                n++;
                if (n == 3) req = '0;
            end
        end
        check("sole_count", 32'(n), 32'd3);

        // Operand change during COMP does not affect the result.
        wait_idle();
        set_op(1, 8'h0A, 8'h14, 1'b0);
        sb.push_back('{1, 1'b0, 1'b0, 1'b1});
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        set_op(1, 8'hC8, 8'h14, 1'b1);
        wait_done(1);
        req = '0;

        // Reset during COMP aborts the op; next grant goes to requester 0.
        wait_idle();
        set_op(2, 8'h33, 8'h22, 1'b0);
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("midrst_outs", {18'd0, gnt, done, mayor, igual, menor, busy}, 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst_idle", 32'(busy), 32'd0);
        set_op(0, 8'h11, 8'h11, 1'b0);
        sb.push_back('{0, 1'b0, 1'b1, 1'b0});
        req = 4'hF;
        @(negedge clk);
        check("post_rst_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'b0001;
        wait_done(0);
        req = '0;

`ifdef COMP_ARB_CNT_EN
        wait_idle();
        do_reset();
        for (int i = 0; i < 5; i++) run_op(3, 8'h01, 8'h02, 1'b0, model(3, 8'h01, 8'h02, 1'b0));
        @(negedge clk);
        check("opcount5", 32'(opcount), 32'd5);
        force dut.op_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.op_cnt_q;
        for (int i = 0; i < 3; i++) run_op(3, 8'h02, 8'h01, 1'b0, model(3, 8'h02, 8'h01, 1'b0));
        @(negedge clk);
        check("opcount_sat", 32'(opcount), 32'hFFFF);
`endif

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
